// File: rtl/regfile_write_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : regfile_write_sequencer
// Purpose  : Write-side driver for the 32x32 register file. After reset it
//            sweeps reg[i] = i for i = INIT_LO..INIT_HI through the normal
//            write port, then drains buffered writeback requests in order,
//            one per cycle. A pending-write lookup exposes uncommitted writes.
// Options  : WSEQ_LOOKUP_EN - enables the combinational pending-write search;
//            when undefined lk_hit/lk_data are tied low.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_sequencer #(
    parameter int DEPTH   = 4,
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int INIT_LO = 16,
    parameter int INIT_HI = 30
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_rd,
    input  logic [DW-1:0] req_data,
    output logic          RegWrite,
    output logic [AW-1:0] rd,
    output logic [DW-1:0] Data_In,
    output logic          init_done,
    output logic          busy,
    input  logic [AW-1:0] lk_addr,
    output logic          lk_hit,
    output logic [DW-1:0] lk_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + DW;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   mem_d [DEPTH];
    logic            we_q, we_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [DW-1:0]   data_q, data_d;
    logic            done_q, done_d;

    logic            w_ready;
    logic            w_push;
    logic            w_pop;
    logic [EW-1:0]   w_head;

    // Full-ness alone gates acceptance, so a same-cycle pop never frees a slot early.
    assign w_ready = (count_q != CW'(DEPTH));
    assign w_push  = req_valid & w_ready;
    assign w_pop   = (state_q == ST_RUN) && (count_q != '0);
    assign w_head  = mem_q[rd_ptr_q];

    // Request FIFO bookkeeping: pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = {req_rd, req_data};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(w_push) - CW'(w_pop);
    end

    // Next-state and write-port stage: init sweep first, then FIFO drain.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        rd_d    = rd_q;
        data_d  = data_q;
        done_d  = done_q;
        case (state_q)
            ST_INIT: begin
                we_d   = 1'b1;
                rd_d   = cnt_q;
                data_d = DW'(cnt_q);
                cnt_d  = cnt_q + AW'(1);
                if (cnt_q == AW'(INIT_HI)) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_pop) begin
                    we_d   = 1'b1;
                    rd_d   = w_head[EW-1:DW];
                    data_d = w_head[DW-1:0];
                end else begin
                    // Address/data hold their last values while idle.
                    we_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Control and output-stage registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_INIT;
            cnt_q    <= AW'(INIT_LO);
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    // FIFO storage needs no reset; validity is tracked by count/pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign RegWrite  = we_q;
    assign rd        = rd_q;
    assign Data_In   = data_q;
    assign init_done = done_q;
    assign req_ready = w_ready;
    assign busy      = (count_q != '0) | we_q | (state_q == ST_INIT);

`ifdef WSEQ_LOOKUP_EN
    logic [PW-1:0] w_lk_idx;

    // Newest pending write wins: output stage first, then FIFO oldest to newest.
    always_comb begin
        lk_hit   = 1'b0;
        lk_data  = '0;
        w_lk_idx = '0;
        if (we_q && (rd_q == lk_addr)) begin
            lk_hit  = 1'b1;
            lk_data = data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_lk_idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (mem_q[w_lk_idx][EW-1:DW] == lk_addr)) begin
                lk_hit  = 1'b1;
                lk_data = mem_q[w_lk_idx][DW-1:0];
            end
        end
    end
`else
    logic w_lk_unused;

    assign lk_hit      = 1'b0;
    assign lk_data     = '0;
    assign w_lk_unused = ^lk_addr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_sequencer
// Purpose  : Self-checking bench for regfile_write_sequencer against a
//            queue-based reference model of the write stream.
// Options  : WSEQ_LOOKUP_EN - also checks the pending-write lookup contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_sequencer;

    localparam int DEPTH   = 4;
    localparam int AW      = 5;
    localparam int DW      = 32;
    localparam int INIT_LO = 16;
    localparam int INIT_HI = 30;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_rd = '0;
    logic [DW-1:0] req_data = '0;
    logic          RegWrite;
    logic [AW-1:0] rd;
    logic [DW-1:0] Data_In;
    logic          init_done;
    logic          busy;
    logic [AW-1:0] lk_addr = '0;
    logic          lk_hit;
    logic [DW-1:0] lk_data;

    int checks = 0;
    int errors = 0;

    // Reference model: pending requests as a queue, plus the visible write port.
    logic [AW+DW-1:0] m_q[$];
    bit               m_init;
    int               m_cnt;
    logic             m_we;
    logic [AW-1:0]    m_rd;
    logic [DW-1:0]    m_data;
    logic             m_done;

    regfile_write_sequencer #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .INIT_LO(INIT_LO), .INIT_HI(INIT_HI)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rd(req_rd), .req_data(req_data),
        .RegWrite(RegWrite), .rd(rd), .Data_In(Data_In),
        .init_done(init_done), .busy(busy),
        .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_busy();
        return (m_q.size() != 0) || m_we || m_init;
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_init = 1'b1;
        m_cnt  = INIT_LO;
        m_we   = 1'b0;
        m_rd   = '0;
        m_data = '0;
        m_done = 1'b0;
    endtask

    task automatic m_lookup(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
`ifdef WSEQ_LOOKUP_EN
        if (m_we && m_rd == a) begin
            h = 1'b1;
            d = m_data;
        end
        for (int i = 0; i < m_q.size(); i++) begin
            if (m_q[i][AW+DW-1:DW] == a) begin
                h = 1'b1;
                d = m_q[i][DW-1:0];
            end
        end
`endif
    endtask

    task automatic compare_all();
        logic          h;
        logic [DW-1:0] d;
        m_lookup(lk_addr, h, d);
        chk("RegWrite", RegWrite, m_we);
        chk("rd", rd, m_rd);
        chk("Data_In", Data_In, m_data);
        chk("init_done", init_done, m_done);
        chk("busy", busy, m_busy());
        chk("req_ready", req_ready, m_q.size() != DEPTH);
        chk("lk_hit", lk_hit, h);
        chk("lk_data", lk_data, d);
    endtask

    // One clock edge: model advances with pre-edge inputs, then outputs are compared.
    task automatic step(output bit acc);
        logic [AW+DW-1:0] e;
        acc = req_valid && (m_q.size() != DEPTH);
        e   = {req_rd, req_data};
        @(posedge clk);
        if (m_init) begin
            m_we   = 1'b1;
            m_rd   = AW'(m_cnt);
            m_data = DW'(m_cnt);
            if (m_cnt == INIT_HI) begin
                m_init = 1'b0;
                m_done = 1'b1;
            end
            m_cnt++;
        end else if (m_q.size() != 0) begin
            logic [AW+DW-1:0] h;
            h      = m_q.pop_front();
            m_we   = 1'b1;
            m_rd   = h[AW+DW-1:DW];
            m_data = h[DW-1:0];
        end else begin
            m_we = 1'b0;
        end
        if (acc) m_q.push_back(e);
        #1;
        compare_all();
    endtask

    task automatic drain();
        bit acc;
        req_valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step(acc);
            if (!m_busy()) break;
        end
        chk("drain_idle", busy, 1'b0);
    endtask

    // Asynchronous reset pulse placed mid-cycle; outputs must clear immediately.
    task automatic pulse_reset();
        #3;
        rst = 1'b0;
        #1;
        m_reset();
        chk("async_RegWrite", RegWrite, 1'b0);
        compare_all();
        #2;
        rst = 1'b1;
    endtask

    initial begin
        bit acc;
        int nxt;

        // Power-on reset
        #1 rst = 1'b0;
        m_reset();
        #2;
        compare_all();
        #9 rst = 1'b1;

        // Requests held from reset release: four fill the FIFO during INIT.
        nxt = 1;
        for (int c = 0; c < 100 && nxt <= 6; c++) begin
            req_valid = 1'b1;
            req_rd    = AW'(nxt);
            req_data  = DW'(32'hA0 + nxt);
            step(acc);
            if (acc) nxt++;
        end
        if (nxt <= 6) begin
            checks++;
            errors++;
            $error("FAIL hold_accept observed=%0d expected=7", nxt);
        end
        drain();

        // Single request after init: visible for exactly one cycle.
        req_valid = 1'b1;
        req_rd    = 5'd5;
        req_data  = 32'hDEADBEEF;
        step(acc);
        req_valid = 1'b0;
        step(acc);
        chk("single_we", RegWrite, 1'b1);
        chk("single_rd", rd, 5'd5);
        chk("single_data", Data_In, 32'hDEADBEEF);
        step(acc);
        chk("single_we_off", RegWrite, 1'b0);
        chk("single_busy_off", busy, 1'b0);

        // Randomised traffic in RUN with small address range to create lookup hits.
        for (int c = 0; c < 300; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_rd    = AW'($urandom_range(0, 7));
            req_data  = $urandom;
            lk_addr   = AW'($urandom_range(0, 7));
            step(acc);
        end
        drain();

        // Restart INIT and queue two writes to the same register.
        pulse_reset();
        req_valid = 1'b1;
        req_rd    = 5'd7;
        req_data  = 32'h11;
        step(acc);
        req_data  = 32'h22;
        step(acc);
        req_valid = 1'b0;
        lk_addr   = 5'd7;
        #1;
`ifdef WSEQ_LOOKUP_EN
        chk("lk7_hit", lk_hit, 1'b1);
        chk("lk7_data", lk_data, 32'h22);
`else
        chk("lk7_hit_tied", lk_hit, 1'b0);
        chk("lk7_data_tied", lk_data, 32'h0);
`endif
        lk_addr = 5'd8;
        #1;
        chk("lk8_hit", lk_hit, 1'b0);
        chk("lk8_data", lk_data, 32'h0);

        // Third pending entry, then reset mid-INIT: all three must be discarded.
        req_valid = 1'b1;
        req_rd    = 5'd9;
        req_data  = 32'h33;
        step(acc);
        req_valid = 1'b0;
        step(acc);
        pulse_reset();

        // Fresh sweep with random pushes and lookups during INIT, then drain.
        for (int c = 0; c < 40; c++) begin
            req_valid = ($urandom_range(0, 1) != 0);
            req_rd    = AW'($urandom_range(0, 7));
            req_data  = $urandom;
            lk_addr   = AW'($urandom_range(0, 7));
            step(acc);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_write_sequencer.md
Name: regfile_write_sequencer

Overview:
- Write-side driver for the multicycle datapath's 32x32 register file; owns its RegWrite/rd/Data_In inputs.
- After reset, sweeps the initialisation pattern (reg[i] = i for i = INIT_LO..INIT_HI) through the normal write port.
- After the sweep, drains buffered writeback requests from the datapath in order, one per cycle.
- Provides a pending-write lookup so the read side can see writes not yet committed.

Parameters:
- DEPTH, 4, request FIFO entries (power of two, >= 2)
- AW, 5, register address width
- DW, 32, data width
- INIT_LO, 16, first register written by the init sweep
- INIT_HI, 30, last register written by the init sweep (INIT_HI >= INIT_LO)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req_valid  in  1  writeback request valid
- req_ready  out  1  request accepted when valid & ready at clk edge
- req_rd  in  AW  destination register
- req_data  in  DW  write data
- RegWrite  out  1  register-file write enable (registered)
- rd  out  AW  register-file write address (registered)
- Data_In  out  DW  register-file write data (registered)
- init_done  out  1  sticky high once init sweep finished
- busy  out  1  FIFO non-empty, RegWrite high, or in INIT
- lk_addr  in  AW  lookup address
- lk_hit  out  1  pending write to lk_addr exists
- lk_data  out  DW  newest pending data for lk_addr

Behaviour:
- Reset (rst=0, async): RegWrite=0, rd=0, Data_In=0, init_done=0, FIFO empty, state=INIT, init counter=INIT_LO.
- States: INIT, RUN. INIT -> RUN after the INIT_HI write is issued. RUN has no exit except reset.
- INIT, each edge: RegWrite<=1, rd<=cnt, Data_In<=cnt zero-extended to DW, cnt++.
- INIT length: exactly INIT_HI-INIT_LO+1 cycles (15 by default), RegWrite held high throughout.
- init_done<=1 on the edge that issues the INIT_HI write. First RUN write can appear on the following edge.
- FIFO accepts during both states. req_ready = (count != DEPTH), depends only on count.
  - When full, no push, even if a pop occurs in the same cycle.
- RUN, FIFO non-empty at edge: pop head into rd/Data_In, RegWrite<=1.
- RUN, FIFO empty at edge: RegWrite<=0; rd/Data_In hold last values.
- Latency: request accepted at edge N into an empty FIFO in RUN -> RegWrite=1 with that rd/data from edge N+1 to N+2. Register file commits at edge N+2.
- Simultaneous push and pop: count unchanged. Throughput is one write per cycle.
- Ordering: strict FIFO; duplicate rd values are all written, in order.
- No address filtering: every rd, including 0, is written.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- busy = (count != 0) | RegWrite | (state == INIT).
- Reset mid-operation: pending entries discarded, output stage cleared, INIT restarts at INIT_LO.

Optional Feature:
- Macro: WSEQ_LOOKUP_EN.
- Defined:
  - lk_hit/lk_data are combinational.
  - Search covers all valid FIFO entries plus the output stage when RegWrite=1.
  - Newest match wins; FIFO tail-most entry beats older entries, and any FIFO match beats the output stage.
  - No match: lk_hit=0, lk_data=0.
- Not defined: lk_hit and lk_data tied to 0; lk_addr unused; no search logic synthesised.

Test Plan:
- Release reset, req_valid=0 -> 15 consecutive cycles RegWrite=1, rd=16..30, Data_In=16..30; init_done rises with the rd=30 write; RegWrite=0 the next cycle.
- After init, one request rd=5, data=0xDEADBEEF at edge N -> RegWrite=1, rd=5, Data_In=0xDEADBEEF for exactly one cycle starting edge N+1; busy low afterwards.
- Hold req_valid from reset release with rd=1..6, data=0xA1..0xA6 -> entries 1..4 accepted, req_ready=0 until INIT ends; after rd=30, writes rd=1,2,3,4,5,6 appear on consecutive cycles, in order.
- WSEQ_LOOKUP_EN: during INIT push rd=7/0x11 then rd=7/0x22 -> lk_addr=7 gives lk_hit=1, lk_data=0x22; lk_addr=8 gives lk_hit=0, lk_data=0.
- Assert rst=0 mid-INIT with 3 entries pending -> RegWrite=0 immediately (asynchronous); after release, sweep restarts at rd=16 and the discarded entries are never written.
